// File: rtl/idt_cfg_ctrl_if.sv
// idt_cfg_ctrl_if: SoC-side configuration bus of the IDT synthesizer controller.
// Latency: n/a (signal bundle only).
// Backpressure: none on the bus; a write while busy is dropped and flagged by cfg_ovf.
// Signals: cfg_wr/cfg_wdata (SoC -> ctrl), cfg_rdata/busy/done/cfg_ovf (ctrl -> SoC).
// master modport = SoC side, slave modport = controller side.
interface idt_cfg_ctrl_if;
  logic        cfg_wr;
  logic [23:0] cfg_wdata;
  logic [23:0] cfg_rdata;
  logic        busy;
  logic        done;
  logic        cfg_ovf;

  modport master (
    output cfg_wr, cfg_wdata,
    input  cfg_rdata, busy, done, cfg_ovf
  );

  modport slave (
    input  cfg_wr, cfg_wdata,
    output cfg_rdata, busy, done, cfg_ovf
  );
endinterface

// File: rtl/idt_cfg_ctrl.sv
// idt_cfg_ctrl: shifts a 24-bit word {C,TTL,F,S,V,R} MSB-first to the IDT clock synthesizer, strobes it, waits for PLL settle.
// Latency: cfg_wr accepted in cycle 0 -> done pulse in cycle 1+48*CLK_DIV+STROBE_CYCLES+SETTLE_CYCLES.
// Backpressure: none; cfg_wr while busy is dropped and sets sticky cfg_ovf.
// Ports: clk; reset_ (async, active-low); cfg (slave modport: cfg_wr/cfg_wdata in,
//   cfg_rdata/busy/done/cfg_ovf out); idt_sclk/idt_data/idt_strobe serial pins. All outputs registered.
// Build option: define IDT_CFG_BOOT_EN to load BOOT_CFG and run a full sequence straight out of reset.
module idt_cfg_ctrl #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned STROBE_CYCLES = 8,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter logic [23:0] BOOT_CFG      = 24'h31149F
) (
  input  logic         clk,
  input  logic         reset_,
  idt_cfg_ctrl_if.slave cfg,
  output logic         idt_sclk,
  output logic         idt_data,
  output logic         idt_strobe
);

`ifdef IDT_CFG_BOOT_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  // Divider counts 0..2*CLK_DIV-1 per bit: low half then high half of sclk.
  localparam int unsigned           DIV_W    = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0]      DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [15:0]           STB_LAST = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0]           SET_LAST = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_STROBE = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // With the boot option the reset state is mid-flight: first shift bit already on the pins.
  localparam state_t      RST_STATE = BOOT_EN ? ST_SHIFT : ST_IDLE;
  localparam logic [23:0] RST_WORD  = BOOT_EN ? BOOT_CFG : 24'h0;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [23:0]      shreg_q, shreg_d;
  logic [23:0]      rdata_q, rdata_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             data_q, data_d;
  logic             strobe_q, strobe_d;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= RST_STATE;
      div_q    <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      shreg_q  <= RST_WORD;
      rdata_q  <= RST_WORD;
      ovf_q    <= 1'b0;
      busy_q   <= BOOT_EN;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      data_q   <= RST_WORD[23];
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    rdata_d = rdata_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg.cfg_wr) begin
          state_d = ST_SHIFT;
          shreg_d = cfg.cfg_wdata;
          rdata_d = cfg.cfg_wdata;
          ovf_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        // End of a bit's high phase = sclk falling edge: advance to the next bit.
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          shreg_d = {shreg_q[22:0], 1'b0};
          if (bit_q == 5'd23) begin
            state_d = ST_STROBE;
            cnt_d   = '0;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == STB_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && cfg.cfg_wr) ovf_d = 1'b1;

    // Output flops are fed from next-state values so pins change with the state, not a cycle later.
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_q == ST_SETTLE) && (state_d == ST_IDLE);
    sclk_d   = (state_d == ST_SHIFT) && (div_d >= DIV_HALF);
    data_d   = (state_d == ST_SHIFT) && shreg_d[23];
    strobe_d = (state_d == ST_STROBE);
  end

  assign cfg.cfg_rdata = rdata_q;
  assign cfg.busy      = busy_q;
  assign cfg.done      = done_q;
  assign cfg.cfg_ovf   = ovf_q;
  assign idt_sclk      = sclk_q;
  assign idt_data      = data_q;
  assign idt_strobe    = strobe_q;

endmodule

// File: tb/tb_idt_cfg_ctrl.sv
// tb_idt_cfg_ctrl: bench for idt_cfg_ctrl; dut0 uses CLK_DIV=2/STROBE=4/SETTLE=8, dut1 uses 1/1/1.
`timescale 1ns/1ps
module tb_idt_cfg_ctrl;
  localparam int D0 = 2, S0 = 4, T0 = 8;
  localparam int D1 = 1, S1 = 1, T1 = 1;
  localparam logic [23:0] BOOT = 24'h31149F;
`ifdef IDT_CFG_BOOT_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif
  localparam logic [23:0] RST_WORD = BOOT_EN ? BOOT : 24'h0;

  logic clk = 1'b0;
  logic rst_n, rst1_n;
  logic sclk0, data0, stb0, sclk1, data1, stb1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  idt_cfg_ctrl_if if0 ();
  idt_cfg_ctrl_if if1 ();

  idt_cfg_ctrl #(.CLK_DIV(D0), .STROBE_CYCLES(S0), .SETTLE_CYCLES(T0), .BOOT_CFG(BOOT)) dut0 (
    .clk(clk), .reset_(rst_n), .cfg(if0),
    .idt_sclk(sclk0), .idt_data(data0), .idt_strobe(stb0));

  idt_cfg_ctrl #(.CLK_DIV(D1), .STROBE_CYCLES(S1), .SETTLE_CYCLES(T1), .BOOT_CFG(BOOT)) dut1 (
    .clk(clk), .reset_(rst1_n), .cfg(if1),
    .idt_sclk(sclk1), .idt_data(data1), .idt_strobe(stb1));

  logic [1:0]  sclk_a, data_a, stb_a, busy_a, done_a, ovf_a, rst_a;
  logic [23:0] rdata_a [2];
  assign sclk_a     = {sclk1, sclk0};
  assign data_a     = {data1, data0};
  assign stb_a      = {stb1, stb0};
  assign busy_a     = {if1.busy, if0.busy};
  assign done_a     = {if1.done, if0.done};
  assign ovf_a      = {if1.cfg_ovf, if0.cfg_ovf};
  assign rst_a      = {rst1_n, rst_n};
  assign rdata_a[0] = if0.cfg_rdata;
  assign rdata_a[1] = if1.cfg_rdata;

  // Reference model: one programming sequence in flight per instance, timed by plain arithmetic.
  typedef struct {
    int          inst;
    logic [23:0] word;
    int          done;
    bit          ovf;
  } exp_t;

  exp_t exp_q [$];
  int   acc_cyc [2];
  int   done_cyc [2];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic int dv(input int i);
    return (i == 0) ? D0 : D1;
  endfunction
  function automatic int sv(input int i);
    return (i == 0) ? S0 : S1;
  endfunction
  function automatic int seq_len(input int i);
    return (i == 0) ? (1 + 48 * D0 + S0 + T0) : (1 + 48 * D1 + S1 + T1);
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] cyc %0d: got %0h, expected %0h", name, i, cyc, act, exp);
    end
  endtask

  task automatic model_accept(input int i, input logic [23:0] w, input int c);
    exp_t e;
    acc_cyc[i]  = c;
    done_cyc[i] = c + seq_len(i);
    e.inst = i;
    e.word = w;
    e.done = done_cyc[i];
    e.ovf  = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic model_wr(input int i, input logic [23:0] w, input int c);
    if (c >= done_cyc[i]) model_accept(i, w, c);
    else if (exp_q.size() > 0) exp_q[exp_q.size() - 1].ovf = 1'b1;
  endtask

  task automatic model_reset(input int i);
    exp_q.delete();
    acc_cyc[i]  = -1;
    done_cyc[i] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_idle(input int i);
    wait_until(done_cyc[i]);
    step();
  endtask

  task automatic do_wr(input int i, input logic [23:0] w);
    if (i == 0) begin
      if0.cfg_wr    = 1'b1;
      if0.cfg_wdata = w;
    end else begin
      if1.cfg_wr    = 1'b1;
      if1.cfg_wdata = w;
    end
    model_wr(i, w, cyc);
    step();
    if0.cfg_wr = 1'b0;
    if1.cfg_wr = 1'b0;
  endtask

  task automatic release_rst(input int i);
    if (i == 0) rst_n = 1'b1;
    else rst1_n = 1'b1;
    // A boot build starts shifting in the cycle reset lifts, as if a write landed one cycle earlier.
    if (BOOT_EN) model_accept(i, BOOT, cyc - 1);
  endtask

  task automatic chk_reset(input int i);
    check("rst_sclk", i, sclk_a[i], 0);
    check("rst_data", i, data_a[i], RST_WORD[23]);
    check("rst_strobe", i, stb_a[i], 0);
    check("rst_busy", i, busy_a[i], BOOT_EN);
    check("rst_done", i, done_a[i], 0);
    check("rst_ovf", i, ovf_a[i], 0);
    check("rst_rdata", i, rdata_a[i], RST_WORD);
  endtask

  // Monitor: decodes the serial stream and compares it, and all status outputs, with the model.
  int          bits [2];
  int          hi_len [2];
  int          stb_len [2];
  logic [23:0] sh [2];
  logic [1:0]  p_sclk, p_stb, stb_seen;

  initial begin
    exp_t e;
    p_sclk   = '0;
    p_stb    = '0;
    stb_seen = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_a[i]) begin
          bits[i] = 0; hi_len[i] = 0; stb_len[i] = 0; sh[i] = '0;
          p_sclk[i] = 1'b0; p_stb[i] = 1'b0; stb_seen[i] = 1'b0;
        end else begin
          check("busy", i, busy_a[i], (cyc > acc_cyc[i]) && (cyc < done_cyc[i]));
          if (sclk_a[i] && !p_sclk[i]) begin
            sh[i] = {sh[i][22:0], data_a[i]};
            bits[i]++;
          end
          if (sclk_a[i]) hi_len[i]++;
          else if (p_sclk[i]) begin
            check("sclk_high", i, hi_len[i], dv(i));
            hi_len[i] = 0;
          end
          if (stb_a[i] && !p_stb[i]) begin
            if (exp_q.size() == 0 || exp_q[0].inst != i) check("strobe", i, stb_a[i], 0);
            else begin
              check("word", i, sh[i], exp_q[0].word);
              check("sclk_rises", i, bits[i], 24);
              stb_seen[i] = 1'b1;
            end
            bits[i] = 0;
          end
          if (stb_a[i]) stb_len[i]++;
          else if (p_stb[i]) begin
            check("strobe_len", i, stb_len[i], sv(i));
            stb_len[i] = 0;
          end
          if (exp_q.size() > 0 && exp_q[0].inst == i && cyc == exp_q[0].done) begin
            e = exp_q.pop_front();
            check("done", i, done_a[i], 1);
            check("rdata", i, rdata_a[i], e.word);
            check("ovf", i, ovf_a[i], e.ovf);
            check("strobe_seen", i, stb_seen[i], 1);
            stb_seen[i] = 1'b0;
          end else begin
            check("done", i, done_a[i], 0);
          end
          p_sclk[i] = sclk_a[i];
          p_stb[i]  = stb_a[i];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0; rst1_n = 1'b0;
    if0.cfg_wr = 1'b0; if0.cfg_wdata = '0;
    if1.cfg_wr = 1'b0; if1.cfg_wdata = '0;
    model_reset(0);
    model_reset(1);
    #2;
    chk_reset(0);
    chk_reset(1);
    repeat (3) step();
    release_rst(0);
    wait_idle(0);

    // Plain write, then a write dropped mid-sequence, then back-to-back at the done cycle.
    do_wr(0, 24'hA5C3F0);
    wait_idle(0);
    c = cyc;
    do_wr(0, 24'h000001);
    wait_until(c + 50);
    do_wr(0, 24'hFFFFFF);
    wait_idle(0);
    do_wr(0, 24'h123456);
    wait_until(done_cyc[0]);
    do_wr(0, 24'h654321);
    wait_idle(0);

    // Reset in shift cycle 30: pins drop at once and no strobe may follow.
    c = cyc;
    do_wr(0, 24'hABCDEF);
    wait_until(c + 30);
    rst_n = 1'b0;
    model_reset(0);
    #1;
    chk_reset(0);
    repeat (3) step();
    release_rst(0);
    wait_idle(0);
    do_wr(0, 24'h0F0F0F);
    wait_idle(0);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0: wait_until(done_cyc[0]);
        1: repeat ($urandom_range(1, 120)) step();
        default: begin
          wait_idle(0);
          repeat ($urandom_range(0, 3)) step();
        end
      endcase
      do_wr(0, 24'($urandom()));
    end
    wait_idle(0);

    // Minimum divider/strobe/settle instance.
    release_rst(1);
    wait_idle(1);
    do_wr(1, 24'h5A5A5A);
    wait_idle(1);
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 2) == 0) wait_until(done_cyc[1]);
      else repeat ($urandom_range(0, 60)) step();
      do_wr(1, 24'($urandom()));
    end
    wait_idle(1);
    wait_idle(0);
    repeat (3) step();
    check("pending", 0, exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
